useq_control: RTL and testbench



---
 rtl/useq_pkg.sv | 29 ++
 rtl/useq_if.sv | 17 +
 rtl/useq_mem.sv | 19 +
 rtl/useq_control.sv | 103 ++++++++++
 tb/tb_useq_control.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/useq_pkg.sv
// Shared types and microinstruction field layout for the micro-sequencer.
package useq_pkg;
  typedef enum logic [1:0] {SEQ_NEXT = 2'b00, SEQ_JUMP = 2'b01, SEQ_BRANCH = 2'b10, SEQ_HALT = 2'b11} seq_op_t;
  typedef enum logic [1:0] {COND_Z = 2'b00, COND_C = 2'b01, COND_S = 2'b10, COND_V = 2'b11} cond_t;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;

  localparam int CSEL_LSB = 16;
  localparam int CINV_BIT = 18;
  localparam int OP_LSB   = 19;
  localparam int RSV_BIT  = 21;
  localparam int TGT_LSB  = 22;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  localparam int FLAG_V = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  // Cond select encoding is not the flag bit order, so map explicitly.
  function automatic logic [1:0] flag_idx(input cond_t c);
    case (c)
      COND_Z:  return 2'(FLAG_Z);
      COND_C:  return 2'(FLAG_C);
      COND_S:  return 2'(FLAG_S);
      default: return 2'(FLAG_V);
    endcase
  endfunction
endpackage

// File: rtl/useq_if.sv
// Host/datapath-facing bundle of the micro-sequencer.
interface useq_if #(parameter int AW = 4, parameter int CW = 16);
  logic              start;
  logic [3:0]        stateBits;
  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [21+AW:0]    prog_data;
  logic [CW-1:0]     ctr_word;
  logic              busy;
  logic              done;
  logic              err;

  modport master (output start, stateBits, prog_we, prog_addr, prog_data,
                  input  ctr_word, busy, done, err);
  modport slave  (input  start, stateBits, prog_we, prog_addr, prog_data,
                  output ctr_word, busy, done, err);
endinterface

// File: rtl/useq_mem.sv
// Microcode store: one synchronous write port, one asynchronous read port.
module useq_mem #(
  parameter int AW = 4,
  parameter int W  = 26
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/useq_control.sv
// Microprogrammed control sequencer driving the datapath control word.
// Optional watchdog abort enabled by defining USEQ_WATCHDOG_EN.
module useq_control
  import useq_pkg::*;
#(
  parameter int AW         = 4,
  parameter int CW         = 16,
  parameter int MAX_CYCLES = 255
) (
  input logic   clk,
  input logic   rst_n,
  useq_if.slave bus
);
  localparam int IW = 22 + AW;

  state_t        state, state_nx;
  logic [AW-1:0] upc, upc_nx;
  logic [IW-1:0] uinst;
  seq_op_t       op;
  cond_t         csel;
  logic          cond;
  logic [AW-1:0] tgt;
  logic          wd_hit;
  logic          err_q, err_nx;
  logic          unused_bits;

  useq_mem #(.AW(AW), .W(IW)) u_mem (
    .clk   (clk),
    .we    (bus.prog_we && (state == IDLE)),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (upc),
    .rdata (uinst)
  );

  assign op   = seq_op_t'(uinst[OP_LSB +: 2]);
  assign csel = cond_t'(uinst[CSEL_LSB +: 2]);
  assign tgt  = uinst[TGT_LSB +: AW];
  assign cond = bus.stateBits[flag_idx(csel)] ^ uinst[CINV_BIT];
  assign unused_bits = uinst[RSV_BIT] ^ (MAX_CYCLES == 0);

`ifdef USEQ_WATCHDOG_EN
  logic [7:0] wd_cnt;

  // Held at zero outside RUN, so every RUN entry starts from a cleared count.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)              wd_cnt <= '0;
    else if (state != RUN)   wd_cnt <= '0;
    else                     wd_cnt <= wd_cnt + 8'd1;

  assign wd_hit = (state == RUN) && (wd_cnt == 8'(MAX_CYCLES - 1));
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      upc   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      upc   <= upc_nx;
      err_q <= err_nx;
    end

  always_comb begin
    state_nx = state;
    upc_nx   = upc;
    err_nx   = err_q;
    case (state)
      IDLE: if (bus.start) begin
        state_nx = RUN;
        upc_nx   = '0;
        err_nx   = 1'b0;
      end
      RUN: begin
        upc_nx = upc + 1'b1;
        case (op)
          SEQ_JUMP:   upc_nx = tgt;
          SEQ_BRANCH: if (cond) upc_nx = tgt;
          SEQ_HALT: begin
            upc_nx   = upc;
            state_nx = DONE;
          end
          default: ;
        endcase
        // HALT wins over the watchdog: a program finishing on its last cycle is clean.
        if (wd_hit && op != SEQ_HALT) begin
          state_nx = DONE;
          err_nx   = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.ctr_word = (state == RUN) ? uinst[CW-1:0] : CW'(NOP_WORD);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.err      = err_q;
endmodule

// File: tb/tb_useq_control.sv
// Directed self-checking bench for useq_control.
module tb_useq_control;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  useq_if #(.AW(4), .CW(16)) bus ();

  useq_control #(.AW(4), .CW(16), .MAX_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] OPN = 2'b00, OPJ = 2'b01, OPB = 2'b10, OPH = 2'b11;
  localparam logic [1:0] CZ = 2'b00, CC = 2'b01;

  function automatic logic [25:0] mk(input logic [1:0] op, input logic [1:0] cs,
                                     input logic inv, input logic [3:0] tgt,
                                     input logic [15:0] cw);
    return {tgt, 1'b0, op, inv, cs, cw};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [25:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic outs(input string tag, input logic [15:0] cw, input logic b, input logic d);
    chk({tag, ".cw"},   32'(bus.ctr_word), 32'(cw));
    chk({tag, ".busy"}, 32'(bus.busy),     32'(b));
    chk({tag, ".done"}, 32'(bus.done),     32'(d));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.stateBits = 4'b0000;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    #1;
    outs("reset", 16'h0000, 1'b0, 1'b0);
    chk("reset.err", 32'(bus.err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic NEXT then HALT
    wr(4'd0, mk(OPN, CZ, 1'b0, 4'd0, 16'h2480));
    wr(4'd1, mk(OPH, CZ, 1'b0, 4'd0, 16'h0008));
    outs("idle", 16'h0000, 1'b0, 1'b0);
    go();
    outs("seq.c1", 16'h2480, 1'b1, 1'b0);
    tick(); outs("seq.c2", 16'h0008, 1'b1, 1'b0);
    tick(); outs("seq.c3", 16'h0000, 1'b1, 1'b1);
    tick(); outs("seq.c4", 16'h0000, 1'b0, 1'b0);

    // BRANCH on Z, no invert
    wr(4'd0, mk(OPB, CZ, 1'b0, 4'd5, 16'h1111));
    wr(4'd5, mk(OPH, CZ, 1'b0, 4'd0, 16'h5555));
    bus.stateBits = 4'b0010;
    go();
    chk("brz.taken.c1", 32'(bus.ctr_word), 32'h1111);
    tick(); chk("brz.taken.c2", 32'(bus.ctr_word), 32'h5555);
    tick(); chk("brz.taken.done", 32'(bus.done), 32'd1);
    tick();
    bus.stateBits = 4'b0000;
    go();
    tick(); chk("brz.nottaken", 32'(bus.ctr_word), 32'h0008);
    tick(); tick();

    // BRANCH on Z inverted; write mem[0] in the same cycle as start
    bus.stateBits = 4'b0010;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd0;
    bus.prog_data = mk(OPB, CZ, 1'b1, 4'd5, 16'h1212);
    bus.start     = 1'b1;
    tick();
    bus.prog_we = 1'b0;
    bus.start   = 1'b0;
    chk("wr_start.c1", 32'(bus.ctr_word), 32'h1212);
    tick(); chk("brzi.nottaken", 32'(bus.ctr_word), 32'h0008);
    tick(); tick();
    bus.stateBits = 4'b0000;
    go();
    tick(); chk("brzi.taken", 32'(bus.ctr_word), 32'h5555);
    tick(); tick();

    // JUMP to 15, NEXT wraps to 0; then reset mid-RUN
    wr(4'd0,  mk(OPJ, CZ, 1'b0, 4'd15, 16'h3000));
    wr(4'd15, mk(OPN, CZ, 1'b0, 4'd0,  16'hF0F0));
    go();
    chk("jmp.c1", 32'(bus.ctr_word), 32'h3000);
    tick(); chk("jmp.c2", 32'(bus.ctr_word), 32'hF0F0);
    tick(); chk("wrap.next", 32'(bus.ctr_word), 32'h3000);
    tick(); chk("jmp.c4", 32'(bus.ctr_word), 32'hF0F0);
    rst_n = 1'b0;
    #1;
    outs("rst_run", 16'h0000, 1'b0, 1'b0);
    tick(); outs("rst_run.hold", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    // C-cond BRANCH at 15 not taken wraps to 0
    wr(4'd0,  mk(OPB, CC, 1'b0, 4'd15, 16'h0C0C));
    wr(4'd15, mk(OPB, CC, 1'b0, 4'd5,  16'hF1F1));
    bus.stateBits = 4'b0001;
    go();
    chk("brc.c1", 32'(bus.ctr_word), 32'h0C0C);
    tick(); chk("brc.at15", 32'(bus.ctr_word), 32'hF1F1);
    bus.stateBits = 4'b0000;
    tick(); chk("wrap.branch", 32'(bus.ctr_word), 32'h0C0C);
    tick(); chk("brc.halt", 32'(bus.ctr_word), 32'h0008);
    tick(); chk("brc.done", 32'(bus.done), 32'd1);
    tick();

    // prog_we and start while busy are ignored
    wr(4'd0, mk(OPN, CZ, 1'b0, 4'd0, 16'h2480));
    go();
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd1;
    bus.prog_data = mk(OPN, CZ, 1'b0, 4'd0, 16'hDEAD);
    bus.start     = 1'b1;
    tick(); chk("busy.nowrite", 32'(bus.ctr_word), 32'h0008);
    tick(); outs("busy.done", 16'h0000, 1'b1, 1'b1);
    bus.prog_we = 1'b0;
    bus.start   = 1'b0;
    tick(); outs("busy.idle", 16'h0000, 1'b0, 1'b0);
    go();
    chk("rerun.c1", 32'(bus.ctr_word), 32'h2480);
    tick(); chk("mem1.kept", 32'(bus.ctr_word), 32'h0008);
    tick(); tick();

    // Endless JUMP 0 loop
    wr(4'd0, mk(OPJ, CZ, 1'b0, 4'd0, 16'h7777));
    go();
    chk("loop.c1", 32'(bus.ctr_word), 32'h7777);
    repeat (6) tick();
    outs("loop.c7", 16'h7777, 1'b1, 1'b0);
`ifdef USEQ_WATCHDOG_EN
    tick(); outs("wd.c8", 16'h7777, 1'b1, 1'b0);
    chk("wd.c8.err", 32'(bus.err), 32'd0);
    tick(); outs("wd.done", 16'h0000, 1'b1, 1'b1);
    chk("wd.err", 32'(bus.err), 32'd1);
    tick(); chk("wd.err.hold", 32'(bus.err), 32'd1);
    chk("wd.idle", 32'(bus.busy), 32'd0);
    go();
    chk("wd.err.clr", 32'(bus.err), 32'd0);
`else
    repeat (4) tick();
    outs("noWD.run", 16'h7777, 1'b1, 1'b0);
    chk("noWD.err", 32'(bus.err), 32'd0);
`endif
    rst_n = 1'b0;
    #1;
    outs("final.rst", 16'h0000, 1'b0, 1'b0);
    chk("final.err", 32'(bus.err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
